// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified memory arbiter: widths, RV32I func3 codes, grant encoding.
package mem_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

  // Halfwords must be 2-byte aligned and words 4-byte aligned; bytes never trap.
  function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (func3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Requester and memory-port signals of the unified memory arbiter.
// slave = arbiter side, master = pipeline/memory side.
interface unified_mem_arbiter_if #(
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_pkg::DATA_W
);
  import mem_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [2:0]        d_func3;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_misalign;

  logic              m_read;
  logic              m_write;
  logic [2:0]        m_func3;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_func3, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_misalign,
    output m_read, m_write, m_func3, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_func3, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_misalign,
    input  m_read, m_write, m_func3, m_addr, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/unified_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter between instruction fetch and data stage.
// Holds the most recent winner; idle cycles leave it unchanged.
module rr_arb2
  import mem_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_if,
  input  logic i_req_mem,
  output logic o_gnt_if,
  output logic o_gnt_mem
);

  grant_e r_last_grant;
  grant_e w_last_grant_d;

  always_comb begin
    o_gnt_if  = 1'b0;
    o_gnt_mem = 1'b0;
    if (i_req_if && i_req_mem) begin
      if (r_last_grant == GNT_IF) o_gnt_mem = 1'b1;
      else                        o_gnt_if  = 1'b1;
    end else if (i_req_if) begin
      o_gnt_if = 1'b1;
    end else if (i_req_mem) begin
      o_gnt_mem = 1'b1;
    end
  end

  always_comb begin
    w_last_grant_d = r_last_grant;
    if (o_gnt_if)  w_last_grant_d = GNT_IF;
    if (o_gnt_mem) w_last_grant_d = GNT_MEM;
  end

  // Resetting to IF makes the first contention go to MEM.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_last_grant <= GNT_IF;
    else          r_last_grant <= w_last_grant_d;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares the single-ported unified I/D memory between IF and MEM stages, one access per cycle.
// Optional build macro: MISALIGN_TRAP_EN (misaligned data accesses are suppressed and flagged).
module unified_mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_pkg::DATA_W
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  unified_mem_arbiter_if.slave   io_bus
);

  logic              w_if_gnt;
  logic              w_d_gnt;
  logic              w_misalign;

  logic              r_if_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_d_misalign;

  rr_arb2 u_rr_arb2 (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req_if  (io_bus.if_req),
    .i_req_mem (io_bus.d_req),
    .o_gnt_if  (w_if_gnt),
    .o_gnt_mem (w_d_gnt)
  );

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = io_bus.d_req & is_misaligned(io_bus.d_func3, io_bus.d_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign io_bus.if_gnt = w_if_gnt;
  assign io_bus.d_gnt  = w_d_gnt;

  always_comb begin
    io_bus.m_read  = 1'b0;
    io_bus.m_write = 1'b0;
    io_bus.m_func3 = 3'b000;
    io_bus.m_addr  = '0;
    io_bus.m_wdata = '0;
    if (w_if_gnt) begin
      io_bus.m_read  = 1'b1;
      io_bus.m_func3 = F3_W;
      io_bus.m_addr  = io_bus.if_addr;
    end else if (w_d_gnt && !w_misalign) begin
      io_bus.m_read  = ~io_bus.d_we;
      io_bus.m_write = io_bus.d_we;
      io_bus.m_func3 = io_bus.d_func3;
      io_bus.m_addr  = io_bus.d_addr;
      io_bus.m_wdata = io_bus.d_wdata;
    end
    // A grant issued while reset is asserted must not touch memory.
    if (!i_rst_n) begin
      io_bus.m_read  = 1'b0;
      io_bus.m_write = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_if_rvalid  <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rvalid   <= 1'b0;
      r_d_rdata    <= '0;
      r_d_misalign <= 1'b0;
    end else begin
      r_if_rvalid  <= w_if_gnt;
      r_d_rvalid   <= w_d_gnt;
      r_d_misalign <= w_d_gnt & w_misalign;
      if (w_if_gnt) r_if_rdata <= io_bus.m_rdata;
      // Stores and trapped accesses return zero; rdata otherwise holds between responses.
      if (w_d_gnt)  r_d_rdata  <= (io_bus.d_we || w_misalign) ? '0 : io_bus.m_rdata;
    end
  end

  assign io_bus.if_rvalid  = r_if_rvalid;
  assign io_bus.if_rdata   = r_if_rdata;
  assign io_bus.d_rvalid   = r_d_rvalid;
  assign io_bus.d_rdata    = r_d_rdata;
  assign io_bus.d_misalign = r_d_misalign;

endmodule
